// File: rtl/sccb_slave_responder_if.sv
// Pin-side and register-file-side signals of the SCCB slave responder.
// The slave modport is the responder; the master modport is the pad/bus model plus register bank.
interface sccb_slave_responder_if;
    logic        scl_i;
    logic        sda_i;
    logic        sda_oe;
    logic        busy;
    logic [15:0] reg_addr;
    logic        reg_wr_en;
    logic [7:0]  reg_wr_data;
    logic        reg_rd_en;
    logic [7:0]  reg_rd_data;
    logic [3:0]  dbg_state;

    // Register-file handshake: reg_wr_en and reg_rd_en are single-cycle strobes
    // with no back-pressure (the bank is always ready). reg_wr_data and reg_addr
    // are valid in the reg_wr_en cycle; reg_rd_data must be valid in the cycle
    // after reg_rd_en and is sampled exactly once, at the end of that cycle.
    modport slave (
        input  scl_i, sda_i, reg_rd_data,
        output sda_oe, busy, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, dbg_state
    );

    modport master (
        output scl_i, sda_i, reg_rd_data,
        input  sda_oe, busy, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, dbg_state
    );
endinterface

// File: rtl/sccb_slave_responder.sv
// SCCB slave with 16-bit register addresses: decodes 3-phase writes and
// 2-phase write + 2-phase read into register-file strobes.
module sccb_slave_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sccb_slave_responder_if.slave io_sccb
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV       = 4'd1,
        DEV_ACK   = 4'd2,
        ADDR_H    = 4'd3,
        ACK_H     = 4'd4,
        ADDR_L    = 4'd5,
        ACK_L     = 4'd6,
        WDATA     = 4'd7,
        ACK_W     = 4'd8,
        RD_BYTE   = 4'd9,
        RD_MACK   = 4'd10,
        WAIT_STOP = 4'd11
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_last_bit;
    logic [7:0] w_byte;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic        r_ack_half;
    logic        r_rw;
    logic        r_rd_pend;
    logic        r_sda_oe;
    logic        r_busy;
    logic [15:0] r_reg_addr;
    logic        r_reg_wr_en;
    logic [7:0]  r_reg_wr_data;
    logic        r_reg_rd_en;

    // Synchronizers reset to the idle bus level so reset release never fakes a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], io_sccb.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], io_sccb.sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 4'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_ack_half    <= 1'b0;
            r_rw          <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_data <= '0;
            r_reg_rd_en   <= 1'b0;
        end else begin
            r_reg_wr_en <= 1'b0;
            r_reg_rd_en <= 1'b0;
            r_rd_pend   <= r_reg_rd_en;
            // Read data arrives one cycle after the request; no SCL edge can land here.
            if (r_rd_pend) begin
                r_shift <= io_sccb.reg_rd_data;
            end

            if (w_start) begin
                r_state    <= DEV;
                r_bit_cnt  <= '0;
                r_ack_half <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b1;
            end else if (w_stop) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_ack_half <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    DEV: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_bit_cnt <= '0;
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    r_state     <= DEV_ACK;
                                    r_rw        <= w_byte[0];
                                    r_reg_rd_en <= w_byte[0];
                                end else begin
                                    r_state <= WAIT_STOP;
                                end
                            end
                        end
                    end

                    ADDR_H: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_bit_cnt        <= '0;
                                r_reg_addr[15:8] <= w_byte;
                                r_state          <= ACK_H;
                            end
                        end
                    end

                    ADDR_L: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_bit_cnt       <= '0;
                                r_reg_addr[7:0] <= w_byte;
                                r_state         <= ACK_L;
                            end
                        end
                    end

                    WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_bit_cnt     <= '0;
                                r_reg_wr_data <= w_byte;
                                r_reg_wr_en   <= 1'b1;
                                r_state       <= ACK_W;
                            end
                        end
                    end

                    // ACK slots: first fall pulls SDA low, second fall releases and advances.
                    DEV_ACK: begin
                        if (w_scl_fall) begin
                            r_ack_half <= ~r_ack_half;
                            r_sda_oe   <= ~r_ack_half;
                            if (r_ack_half) begin
                                if (r_rw) begin
                                    r_sda_oe  <= ~r_shift[7];
                                    r_shift   <= {r_shift[6:0], 1'b0};
                                    r_bit_cnt <= 4'd1;
                                    r_state   <= RD_BYTE;
                                end else begin
                                    r_state <= ADDR_H;
                                end
                            end
                        end
                    end

                    ACK_H: begin
                        if (w_scl_fall) begin
                            r_ack_half <= ~r_ack_half;
                            r_sda_oe   <= ~r_ack_half;
                            if (r_ack_half) begin
                                r_state <= ADDR_L;
                            end
                        end
                    end

                    ACK_L: begin
                        if (w_scl_fall) begin
                            r_ack_half <= ~r_ack_half;
                            r_sda_oe   <= ~r_ack_half;
                            if (r_ack_half) begin
                                r_state <= WDATA;
                            end
                        end
                    end

                    ACK_W: begin
                        if (w_scl_fall) begin
                            r_ack_half <= ~r_ack_half;
                            r_sda_oe   <= ~r_ack_half;
                            if (r_ack_half) begin
                                r_reg_addr <= r_reg_addr + 16'd1;
                                r_state    <= WDATA;
                            end
                        end
                    end

                    RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_state   <= RD_MACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    RD_MACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_reg_addr  <= r_reg_addr + 16'd1;
                                r_reg_rd_en <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_state     <= RD_BYTE;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end

                    WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_sccb.sda_oe      = r_sda_oe;
    assign io_sccb.busy        = r_busy;
    assign io_sccb.reg_addr    = r_reg_addr;
    assign io_sccb.reg_wr_en   = r_reg_wr_en;
    assign io_sccb.reg_wr_data = r_reg_wr_data;
    assign io_sccb.reg_rd_en   = r_reg_rd_en;
    assign io_sccb.dbg_state   = r_state;

endmodule
